id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode and execute. It latches decoded operands and control from ID and drives the EX-stage ALUs (logic, shift, arith) through one-hot unit select, op code and left/right operands. It also detects load-use hazards against the instruction currently in EX, inserting a bubble and requesting an ID stall. Flush and downstream stall are arbitrated here, and inserted bubbles are counted.

## Interface

Parameters:
- `SEL_W`, 4: width of one-hot ALU unit select (bit 0 = logic unit).
- `OP_W`, 8: width of low ALU op code.
- `CNT_W`, 16: width of bubble counter.

Ports:
- `clk` in 1: the single clock, rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `flush` in 1: kill instruction entering EX (exception/redirect).
- `stall_in` in 1: stall request from EX/MEM (multi-cycle op, memory wait).
- `id_valid` in 1: ID holds a real instruction.
- `id_alusel` in SEL_W: one-hot unit select.
- `id_aluop` in OP_W: ALU op code.
- `id_srcLeft`, `id_srcRight` in 32: operands.
- `id_wreg` in 1: instruction writes a GPR.
- `id_waddr` in 5: destination GPR.
- `id_is_load` in 1: instruction is a load.
- `id_rs_used`, `id_rt_used` in 1: source register read.
- `id_rs_addr`, `id_rt_addr` in 5: source register numbers.
- `id_next_in_delay_slot` in 1: instruction in ID is a branch/jump, so the next one is a delay slot.
- `ex_valid` out 1, `ex_alusel` out SEL_W, `ex_aluop` out OP_W, `ex_srcLeft` out 32, `ex_srcRight` out 32, `ex_wreg` out 1, `ex_waddr` out 5, `ex_is_load` out 1: registered EX-stage fields.
- `id_in_delay_slot` out 1: registered. Tells ID its current instruction is a delay slot.
- `stall_id` out 1: combinational. Hold PC and IF/ID.
- `bubble_cnt` out CNT_W: registered. Saturating count of inserted load-use bubbles.

## Operation

- Load-use hazard: `load_use = id_valid & ex_valid & ex_is_load & ex_wreg & (ex_waddr != 0) & ((id_rs_used & id_rs_addr == ex_waddr) | (id_rt_used & id_rt_addr == ex_waddr))`.
- `stall_id = load_use | stall_in`.
- Per-edge action, highest priority first:
  1. `rst` asserted: all registered outputs are 0.
  2. `flush`: load bubble, and clear `id_in_delay_slot`.
  3. `stall_in`: hold all EX registers and `id_in_delay_slot` unchanged.
  4. `load_use`: load bubble. `id_in_delay_slot` holds, because ID is re-presenting the same instruction. `bubble_cnt` increments.
  5. Otherwise: load all `id_*` fields into `ex_*`. `ex_valid <= id_valid`. `id_in_delay_slot <= id_valid & id_next_in_delay_slot`.
- Bubble: `ex_valid`, `ex_alusel`, `ex_aluop`, `ex_srcLeft`, `ex_srcRight`, `ex_wreg`, `ex_waddr` and `ex_is_load` are all 0. With all-zero select, every ALU outputs the zero word.
- When `id_valid = 0` in case 5, all ex fields are still zero-loaded. Invalid instructions never leak nonzero control.
- `bubble_cnt` increments only in case 4 and saturates at all-ones. Flush and stall do not count.
- Register $0 never causes a hazard.

## Timing

- Latency: ID fields appear on `ex_*` one cycle after the sampling edge.
- `stall_id` is purely combinational from current `ex_*` and `id_*`. There is no registered delay.
- A load-use costs exactly one bubble. On the next cycle `ex_valid` is 0, so `load_use` deasserts and the held instruction loads.
- When `flush` and `stall_in` are both high, flush wins: a bubble is loaded.
- When `stall_in` and `load_use` are both high, the hold wins. `load_use` re-evaluates after `stall_in` drops. The counter does not increment during hold.
- Reset mid-stall clears immediately (asynchronously), and `stall_id` drops once `ex_valid` is 0.
- Reset values: every output 0, including `bubble_cnt` and `stall_id` (given `ex_valid` = 0).

## Test plan

- Reset/pass-through:
  - Assert `rst` mid-cycle, then expect all outputs to be 0 without waiting for a clock edge.
  - Release reset, then drive logic select 4'b0001, aluop 8'h24, left 32'hF0F0_0000, right 32'h0000_FFFF, `id_valid` = 1.
  - Required: one edge later, `ex_*` equal those values and `ex_valid` = 1.
- Load-use:
  - EX holds a load to r8 (`ex_wreg` = 1). ID has `id_rs_used` = 1, `id_rs_addr` = 8.
  - Required: `stall_id` = 1 in the same cycle. The next edge gives a bubble (all `ex_*` = 0) and `bubble_cnt` = 1. The following edge loads the ID instruction, and `stall_id` = 0.
- $0 / non-load:
  - A load to r0 with ID reading r0 gives `stall_id` = 0.
  - A non-load ALU op writing r8 with ID reading r8 gives `stall_id` = 0.
- Downstream stall:
  - Assert `stall_in` for 3 cycles with changing `id_*`.
  - Required: `ex_*` held constant and `bubble_cnt` unchanged. New values load on the first edge after `stall_in` drops.
- Flush priority:
  - Assert `flush` and `stall_in` together, with `id_in_delay_slot` = 1.
  - Required: next edge gives `ex_valid` = 0, `ex_srcLeft` = 0 and `id_in_delay_slot` = 0.
- Delay slot and saturation:
  - A valid branch in ID with `id_next_in_delay_slot` = 1 gives `id_in_delay_slot` = 1 after the edge.
  - Preload conditions for 2^CNT_W + 2 load-use events (e.g. CNT_W = 4). Required: `bubble_cnt` stays at 4'hF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decoded ID fields and hazard/flush controls in,
// registered EX-stage fields and the ID stall/delay-slot feedback out.
interface id_ex_stage_if #(
    parameter int SEL_W = 4,
    parameter int OP_W  = 8,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             stall_in;
    logic             id_valid;
    logic [SEL_W-1:0] id_alusel;
    logic [OP_W-1:0]  id_aluop;
    logic [31:0]      id_srcLeft;
    logic [31:0]      id_srcRight;
    logic             id_wreg;
    logic [4:0]       id_waddr;
    logic             id_is_load;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_next_in_delay_slot;

    logic             ex_valid;
    logic [SEL_W-1:0] ex_alusel;
    logic [OP_W-1:0]  ex_aluop;
    logic [31:0]      ex_srcLeft;
    logic [31:0]      ex_srcRight;
    logic             ex_wreg;
    logic [4:0]       ex_waddr;
    logic             ex_is_load;
    logic             id_in_delay_slot;
    logic             stall_id;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output flush, stall_in, id_valid, id_alusel, id_aluop, id_srcLeft,
               id_srcRight, id_wreg, id_waddr, id_is_load, id_rs_used,
               id_rt_used, id_rs_addr, id_rt_addr, id_next_in_delay_slot,
        input  ex_valid, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight,
               ex_wreg, ex_waddr, ex_is_load, id_in_delay_slot, stall_id,
               bubble_cnt
    );

    modport slave (
        input  flush, stall_in, id_valid, id_alusel, id_aluop, id_srcLeft,
               id_srcRight, id_wreg, id_waddr, id_is_load, id_rs_used,
               id_rt_used, id_rs_addr, id_rt_addr, id_next_in_delay_slot,
        output ex_valid, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight,
               ex_wreg, ex_waddr, ex_is_load, id_in_delay_slot, stall_id,
               bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall
// arbitration and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int SEL_W = 4,
    parameter int OP_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  io
);
    logic             ex_valid_q,    ex_valid_d;
    logic [SEL_W-1:0] ex_alusel_q,   ex_alusel_d;
    logic [OP_W-1:0]  ex_aluop_q,    ex_aluop_d;
    logic [31:0]      ex_srcLeft_q,  ex_srcLeft_d;
    logic [31:0]      ex_srcRight_q, ex_srcRight_d;
    logic             ex_wreg_q,     ex_wreg_d;
    logic [4:0]       ex_waddr_q,    ex_waddr_d;
    logic             ex_is_load_q,  ex_is_load_d;
    logic             in_ds_q,       in_ds_d;
    logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;

    logic load_use;
    logic take_id;

    // $0 is hardwired zero, so a load targeting it can never be a real dependency.
    assign load_use = io.id_valid & ex_valid_q & ex_is_load_q & ex_wreg_q
                    & (ex_waddr_q != 5'd0)
                    & ((io.id_rs_used & (io.id_rs_addr == ex_waddr_q))
                     | (io.id_rt_used & (io.id_rt_addr == ex_waddr_q)));

    assign io.stall_id = load_use | io.stall_in;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_alusel_d   = ex_alusel_q;
        ex_aluop_d    = ex_aluop_q;
        ex_srcLeft_d  = ex_srcLeft_q;
        ex_srcRight_d = ex_srcRight_q;
        ex_wreg_d     = ex_wreg_q;
        ex_waddr_d    = ex_waddr_q;
        ex_is_load_d  = ex_is_load_q;
        in_ds_d       = in_ds_q;
        bubble_cnt_d  = bubble_cnt_q;
        take_id       = 1'b0;

        // Flush, load-use and an invalid ID all collapse to a zeroed bubble.
        if (io.flush || !io.stall_in) begin
            take_id       = !io.flush && !load_use && io.id_valid;
            ex_valid_d    = take_id;
            ex_alusel_d   = take_id ? io.id_alusel   : '0;
            ex_aluop_d    = take_id ? io.id_aluop    : '0;
            ex_srcLeft_d  = take_id ? io.id_srcLeft  : '0;
            ex_srcRight_d = take_id ? io.id_srcRight : '0;
            ex_wreg_d     = take_id & io.id_wreg;
            ex_waddr_d    = take_id ? io.id_waddr    : '0;
            ex_is_load_d  = take_id & io.id_is_load;
        end

        if (io.flush) begin
            in_ds_d = 1'b0;
        end else if (!io.stall_in && !load_use) begin
            in_ds_d = io.id_valid & io.id_next_in_delay_slot;
        end

        if (!io.flush && !io.stall_in && load_use && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_alusel_q   <= '0;
            ex_aluop_q    <= '0;
            ex_srcLeft_q  <= '0;
            ex_srcRight_q <= '0;
            ex_wreg_q     <= 1'b0;
            ex_waddr_q    <= '0;
            ex_is_load_q  <= 1'b0;
            in_ds_q       <= 1'b0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_alusel_q   <= ex_alusel_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_srcLeft_q  <= ex_srcLeft_d;
            ex_srcRight_q <= ex_srcRight_d;
            ex_wreg_q     <= ex_wreg_d;
            ex_waddr_q    <= ex_waddr_d;
            ex_is_load_q  <= ex_is_load_d;
            in_ds_q       <= in_ds_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign io.ex_valid         = ex_valid_q;
    assign io.ex_alusel        = ex_alusel_q;
    assign io.ex_aluop         = ex_aluop_q;
    assign io.ex_srcLeft       = ex_srcLeft_q;
    assign io.ex_srcRight      = ex_srcRight_q;
    assign io.ex_wreg          = ex_wreg_q;
    assign io.ex_waddr         = ex_waddr_q;
    assign io.ex_is_load       = ex_is_load_q;
    assign io.id_in_delay_slot = in_ds_q;
    assign io.bubble_cnt       = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage (CNT_W = 4 so saturation is reachable).
module tb_id_ex_stage;
    typedef struct packed {
        logic        v;
        logic [3:0]  sel;
        logic [7:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic        wr;
        logic [4:0]  wa;
        logic        ld;
        logic        rsu;
        logic        rtu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        nds;
    } id_t;

    typedef struct packed {
        logic        v;
        logic [3:0]  sel;
        logic [7:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic        wr;
        logic [4:0]  wa;
        logic        ld;
    } ex_t;

    typedef struct {
        logic       fl;
        logic       st;
        id_t        id;
        logic       e_stall;
        ex_t        e_ex;
        logic       e_ds;
        logic [3:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    id_ex_stage_if #(.SEL_W(4), .OP_W(8), .CNT_W(4)) bus ();
    id_ex_stage #(.SEL_W(4), .OP_W(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    function automatic ex_t exof(id_t i);
        return '{v: i.v, sel: i.sel, op: i.op, l: i.l, r: i.r, wr: i.wr, wa: i.wa, ld: i.ld};
    endfunction

    function automatic ex_t get_ex();
        return '{v: bus.ex_valid, sel: bus.ex_alusel, op: bus.ex_aluop, l: bus.ex_srcLeft,
                 r: bus.ex_srcRight, wr: bus.ex_wreg, wa: bus.ex_waddr, ld: bus.ex_is_load};
    endfunction

    function automatic vec_t mkv(logic fl, logic st, id_t id, logic es, ex_t ex, logic ds, logic [3:0] cnt);
        vec_t t;
        t.fl = fl; t.st = st; t.id = id; t.e_stall = es; t.e_ex = ex; t.e_ds = ds; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input id_t i);
        bus.flush = fl;
        bus.stall_in = st;
        bus.id_valid = i.v;
        bus.id_alusel = i.sel;
        bus.id_aluop = i.op;
        bus.id_srcLeft = i.l;
        bus.id_srcRight = i.r;
        bus.id_wreg = i.wr;
        bus.id_waddr = i.wa;
        bus.id_is_load = i.ld;
        bus.id_rs_used = i.rsu;
        bus.id_rt_used = i.rtu;
        bus.id_rs_addr = i.rs;
        bus.id_rt_addr = i.rt;
        bus.id_next_in_delay_slot = i.nds;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex"}, 84'(get_ex()), 84'(0));
        chk({tag, "_ds"}, 84'(bus.id_in_delay_slot), 84'(0));
        chk({tag, "_cnt"}, 84'(bus.bubble_cnt), 84'(0));
    endtask

    initial begin
        id_t I_ZERO, I_ALU0, I_LD8, I_RD8, I_LD0, I_RD0, I_RD8B, I_S1, I_S2, I_S3;
        id_t I_BR, I_FL, I_LD5, I_RD5, I_INV;
        ex_t BUB;
        vec_t vq[$];

        BUB    = '0;
        I_ZERO = '0;
        I_ALU0 = '{v:1, sel:4'h1, op:8'h24, l:32'hF0F0_0000, r:32'h0000_FFFF, wr:1, wa:5'd3, ld:0, rsu:0, rtu:0, rs:0, rt:0, nds:0};
        I_LD8  = '{v:1, sel:4'h8, op:8'h01, l:32'h0000_0100, r:32'h4, wr:1, wa:5'd8, ld:1, rsu:1, rtu:0, rs:5'd3, rt:0, nds:1};
        I_RD8  = '{v:1, sel:4'h1, op:8'h25, l:32'h1, r:32'h2, wr:1, wa:5'd9, ld:0, rsu:1, rtu:0, rs:5'd8, rt:0, nds:0};
        I_LD0  = '{v:1, sel:4'h2, op:8'h03, l:32'h5, r:32'h6, wr:1, wa:5'd0, ld:1, rsu:0, rtu:0, rs:0, rt:0, nds:0};
        I_RD0  = '{v:1, sel:4'h1, op:8'h26, l:32'h7, r:32'h8, wr:1, wa:5'd8, ld:0, rsu:0, rtu:1, rs:0, rt:5'd0, nds:0};
        I_RD8B = '{v:1, sel:4'h4, op:8'h27, l:32'h9, r:32'hA, wr:1, wa:5'd10, ld:0, rsu:1, rtu:0, rs:5'd8, rt:0, nds:0};
        I_S1   = '{v:1, sel:4'h2, op:8'h31, l:32'h11, r:32'h1, wr:1, wa:5'd1, ld:0, rsu:0, rtu:0, rs:0, rt:0, nds:0};
        I_S2   = '{v:1, sel:4'h4, op:8'h32, l:32'h12, r:32'h2, wr:1, wa:5'd2, ld:1, rsu:0, rtu:0, rs:0, rt:0, nds:1};
        I_S3   = '{v:1, sel:4'h8, op:8'h33, l:32'h13, r:32'h3, wr:0, wa:5'd3, ld:0, rsu:0, rtu:0, rs:0, rt:0, nds:0};
        I_BR   = '{v:1, sel:4'h1, op:8'h28, l:32'h20, r:32'h21, wr:0, wa:5'd0, ld:0, rsu:0, rtu:0, rs:0, rt:0, nds:1};
        I_FL   = '{v:1, sel:4'h2, op:8'h29, l:32'hABCD_1234, r:32'h22, wr:1, wa:5'd4, ld:0, rsu:0, rtu:0, rs:0, rt:0, nds:1};
        I_LD5  = '{v:1, sel:4'h1, op:8'h02, l:32'h30, r:32'h31, wr:1, wa:5'd5, ld:1, rsu:0, rtu:0, rs:0, rt:0, nds:0};
        I_RD5  = '{v:1, sel:4'h4, op:8'h2A, l:32'h40, r:32'h41, wr:1, wa:5'd6, ld:0, rsu:0, rtu:1, rs:0, rt:5'd5, nds:0};
        I_INV  = '{v:0, sel:4'hF, op:8'hFF, l:32'hDEAD_BEEF, r:32'hFFFF_FFFF, wr:1, wa:5'd7, ld:1, rsu:0, rtu:0, rs:0, rt:0, nds:1};

        //                 fl st  id       pre-stall  ex after edge  ds  cnt
        vq.push_back(mkv(0, 0, I_ALU0, 0, exof(I_ALU0), 0, 4'd0));
        vq.push_back(mkv(0, 0, I_LD8,  0, exof(I_LD8),  1, 4'd0));
        vq.push_back(mkv(0, 0, I_RD8,  1, BUB,          1, 4'd1));
        vq.push_back(mkv(0, 0, I_RD8,  0, exof(I_RD8),  0, 4'd1));
        vq.push_back(mkv(0, 0, I_LD0,  0, exof(I_LD0),  0, 4'd1));
        vq.push_back(mkv(0, 0, I_RD0,  0, exof(I_RD0),  0, 4'd1));
        vq.push_back(mkv(0, 0, I_RD8B, 0, exof(I_RD8B), 0, 4'd1));
        vq.push_back(mkv(0, 1, I_S1,   1, exof(I_RD8B), 0, 4'd1));
        vq.push_back(mkv(0, 1, I_S2,   1, exof(I_RD8B), 0, 4'd1));
        vq.push_back(mkv(0, 1, I_S3,   1, exof(I_RD8B), 0, 4'd1));
        vq.push_back(mkv(0, 0, I_BR,   0, exof(I_BR),   1, 4'd1));
        vq.push_back(mkv(1, 1, I_FL,   1, BUB,          0, 4'd1));
        vq.push_back(mkv(0, 0, I_LD5,  0, exof(I_LD5),  0, 4'd1));
        vq.push_back(mkv(0, 1, I_RD5,  1, exof(I_LD5),  0, 4'd1));
        vq.push_back(mkv(0, 0, I_RD5,  1, BUB,          0, 4'd2));
        vq.push_back(mkv(0, 0, I_RD5,  0, exof(I_RD5),  0, 4'd2));
        vq.push_back(mkv(0, 0, I_INV,  0, BUB,          0, 4'd2));

        rst = 1'b1;
        drive(0, 0, I_ZERO);
        #3;
        chk_all_zero("reset");
        chk("reset_stall", 84'(bus.stall_id), 84'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].fl, vq[i].st, vq[i].id);
            #1;
            chk($sformatf("v%0d_stall", i), 84'(bus.stall_id), 84'(vq[i].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex", i), 84'(get_ex()), 84'(vq[i].e_ex));
            chk($sformatf("v%0d_ds", i), 84'(bus.id_in_delay_slot), 84'(vq[i].e_ds));
            chk($sformatf("v%0d_cnt", i), 84'(bus.bubble_cnt), 84'(vq[i].e_cnt));
        end

        // Asynchronous reset in the middle of a stall, away from any clock edge.
        @(negedge clk);
        drive(0, 0, I_LD8);
        @(posedge clk);
        #1;
        chk("pre_rst_ex", 84'(get_ex()), 84'(exof(I_LD8)));
        @(negedge clk);
        drive(0, 1, I_RD8);
        #1;
        chk("pre_rst_stall", 84'(bus.stall_id), 84'(1));
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        chk("async_rst_stall_in", 84'(bus.stall_id), 84'(1));
        @(negedge clk);
        bus.stall_in = 1'b0;
        #1;
        chk("async_rst_stall_drop", 84'(bus.stall_id), 84'(0));
        rst = 1'b0;

        // 2^CNT_W + 2 load-use events: counter must stick at all-ones.
        for (int e = 0; e < 18; e++) begin
            @(negedge clk);
            drive(0, 0, I_LD8);
            @(negedge clk);
            drive(0, 0, I_RD8);
            #1;
            chk($sformatf("sat%0d_stall", e), 84'(bus.stall_id), 84'(1));
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_cnt", e), 84'(bus.bubble_cnt), 84'((e + 1 > 15) ? 15 : e + 1));
            @(negedge clk);
            drive(0, 0, I_RD8);
        end
        @(posedge clk);
        #1;
        chk("sat_final_ex", 84'(get_ex()), 84'(exof(I_RD8)));
        chk("sat_final_cnt", 84'(bus.bubble_cnt), 84'(15));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
